pingpong_reorder_buffer: RTL and testbench

- Parametrised double-buffered (ping-pong) reorder buffer for the FFT output path. It takes two samples per beat from a radix-2 butterfly stage and streams them out one per beat in natural order.
- It undoes the bit-reversed ordering of the pipelined FFT for an N = 2^LOG2N point frame.
- Successor of the fixed 32-point buffer. Adds parametrised width and depth, valid/ready handshakes on both sides with backpressure, and a last-sample marker.

---
 rtl/pingpong_reorder_buffer.sv | 124 ++++++++++++
 tb/tb_pingpong_reorder_buffer.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pingpong_reorder_buffer.sv
// Ping-pong reorder buffer: two N-word banks undo the bit-reversed order of a radix-2 FFT.
// Optional natural-order write mode is enabled by defining PPB_NATURAL_MODE_EN.
module pingpong_reorder_buffer #(
  parameter int WORD_LEN = 11,
  parameter int LOG2N    = 5
) (
  input  logic                  clk,
  input  logic                  i_rst,
`ifdef PPB_NATURAL_MODE_EN
  input  logic                  i_mode,
`endif
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2*WORD_LEN-1:0] MemInUp,
  input  logic [2*WORD_LEN-1:0] MemInDown,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [2*WORD_LEN-1:0] MemOut,
  output logic [LOG2N-1:0]      out_index,
  output logic                  out_last
);

  localparam int N  = 1 << LOG2N;
  localparam int SW = 2 * WORD_LEN;

  logic [SW-1:0]    mem [2][N];
  logic [1:0]       full;
  logic [1:0]       full_nxt;
  logic             wr_bank;
  logic             rd_bank;
  logic [LOG2N-2:0] wr_cnt;
  logic [LOG2N-1:0] rd_cnt;
  logic             wr_acc;
  logic             rd_acc;
  logic             wr_wrap;
  logic             rd_wrap;
  logic [LOG2N-1:0] addr_up;
  logic [LOG2N-1:0] addr_dn;

  function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] a);
    logic [LOG2N-1:0] r;
    for (int i = 0; i < LOG2N; i++) begin
      r[i] = a[LOG2N-1-i];
    end
    return r;
  endfunction

  assign in_ready  = !full[wr_bank];
  assign out_valid = full[rd_bank];
  assign MemOut    = mem[rd_bank][rd_cnt];
  assign out_index = rd_cnt;
  assign out_last  = out_valid && (rd_cnt == {LOG2N{1'b1}});

  assign wr_acc  = in_valid && in_ready;
  assign rd_acc  = out_valid && out_ready;
  assign wr_wrap = wr_acc && (wr_cnt == {(LOG2N-1){1'b1}});
  assign rd_wrap = rd_acc && (rd_cnt == {LOG2N{1'b1}});

`ifdef PPB_NATURAL_MODE_EN
  logic [1:0] mode_q;
  logic       wr_mode;

  // The first beat of a frame uses i_mode directly; later beats use the latched value.
  assign wr_mode = (wr_cnt == '0) ? i_mode : mode_q[wr_bank];

  always_ff @(posedge clk) begin
    if (i_rst) begin
      mode_q <= 2'b00;
    end else if (wr_acc && (wr_cnt == '0)) begin
      mode_q[wr_bank] <= i_mode;
    end
  end

  always_comb begin
    addr_up = bitrev({wr_cnt, 1'b0});
    addr_dn = bitrev({wr_cnt, 1'b1});
    if (wr_mode) begin
      addr_up = {wr_cnt, 1'b0};
      addr_dn = {wr_cnt, 1'b1};
    end
  end
`else
  always_comb begin
    addr_up = bitrev({wr_cnt, 1'b0});
    addr_dn = bitrev({wr_cnt, 1'b1});
  end
`endif

  // Set and clear always target opposite banks, so both may take effect together.
  always_comb begin
    full_nxt = full;
    if (wr_wrap) full_nxt[wr_bank] = 1'b1;
    if (rd_wrap) full_nxt[rd_bank] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      full    <= 2'b00;
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      wr_cnt  <= '0;
      rd_cnt  <= '0;
    end else begin
      full <= full_nxt;
      if (wr_acc) begin
        wr_cnt <= wr_cnt + 1'b1;
        if (wr_wrap) wr_bank <= !wr_bank;
      end
      if (rd_acc) begin
        rd_cnt <= rd_cnt + 1'b1;
        if (rd_wrap) rd_bank <= !rd_bank;
      end
    end
  end

  // Sample storage is never reset; stale contents are hidden behind out_valid.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wr_bank][addr_up] <= MemInUp;
      mem[wr_bank][addr_dn] <= MemInDown;
    end
  end

endmodule

// File: tb/tb_pingpong_reorder_buffer.sv
// Scoreboard bench for pingpong_reorder_buffer: a 32-point instance and an 8-point, 16-bit instance.
module tb_pingpong_reorder_buffer;

  typedef struct {
    logic [21:0] data;
    logic [4:0]  idx;
    logic        last;
  } exp_t;

  logic        clk = 1'b0;
  logic        i_rst;
  logic        mode;
  logic        in_valid;
  logic        in_ready;
  logic [21:0] MemInUp;
  logic [21:0] MemInDown;
  logic        out_valid;
  logic        out_ready;
  logic [21:0] MemOut;
  logic [4:0]  out_index;
  logic        out_last;

  logic        s_in_valid;
  logic        s_in_ready;
  logic [31:0] s_up;
  logic [31:0] s_dn;
  logic        s_out_valid;
  logic        s_out_ready;
  logic [31:0] s_out;
  logic [2:0]  s_out_index;
  logic        s_out_last;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   gaps     = 0;
  int   waits    = 0;
  bit   gap_watch = 0;
  bit   saw_block = 0;
  bit   rnd_done  = 0;

  always #5 clk = ~clk;

  pingpong_reorder_buffer #(.WORD_LEN(11), .LOG2N(5)) u_dut (
    .clk(clk),
    .i_rst(i_rst),
`ifdef PPB_NATURAL_MODE_EN
    .i_mode(mode),
`endif
    .in_valid(in_valid),
    .in_ready(in_ready),
    .MemInUp(MemInUp),
    .MemInDown(MemInDown),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .MemOut(MemOut),
    .out_index(out_index),
    .out_last(out_last)
  );

  pingpong_reorder_buffer #(.WORD_LEN(16), .LOG2N(3)) u_small (
    .clk(clk),
    .i_rst(i_rst),
`ifdef PPB_NATURAL_MODE_EN
    .i_mode(1'b0),
`endif
    .in_valid(s_in_valid),
    .in_ready(s_in_ready),
    .MemInUp(s_up),
    .MemInDown(s_dn),
    .out_valid(s_out_valid),
    .out_ready(s_out_ready),
    .MemOut(s_out),
    .out_index(s_out_index),
    .out_last(s_out_last)
  );

  function automatic int brev(input int v, input int bits);
    int r = 0;
    for (int i = 0; i < bits; i++) begin
      if (((v >> i) & 1) != 0) r |= 1 << (bits - 1 - i);
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Output monitor: every valid cycle is checked against the scoreboard head.
  always @(negedge clk) begin
    exp_t e;
    if (out_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_out_valid", {27'd0, out_index}, 32'hFFFF_FFFF);
      end else begin
        e = sb[0];
        chk("MemOut", {10'd0, MemOut}, {10'd0, e.data});
        chk("out_index", {27'd0, out_index}, {27'd0, e.idx});
        chk("out_last", {31'd0, out_last}, {31'd0, e.last});
        if (out_ready) void'(sb.pop_front());
      end
    end else if (gap_watch && sb.size() > 0 && out_ready) begin
      gaps++;
    end
  end

  task automatic wait_ready();
    int t = 0;
    @(negedge clk);
    while (!in_ready && t < 2000) begin
      saw_block = 1;
      waits++;
      @(negedge clk);
      t++;
    end
    if (!in_ready) chk("in_ready_timeout", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input int f, input bit md, input int nbeats);
    logic [21:0] fr [32];
    int src;
    for (int n = 0; n < 32; n++) begin
      fr[n][21:11] = 11'((n + 32 * f) & 11'h7FF);
      fr[n][10:0]  = 11'($urandom_range(0, 2047));
    end
    for (int k = 0; k < nbeats; k++) begin
      in_valid  = 1'b1;
      MemInUp   = fr[2*k];
      MemInDown = fr[2*k+1];
      mode      = (k == 0) ? md : ~md;
      wait_ready();
    end
    in_valid = 1'b0;
    if (nbeats == 16) begin
      for (int j = 0; j < 32; j++) begin
        src = md ? j : brev(j, 5);
        sb.push_back('{fr[src], 5'(j), (j == 31)});
      end
    end
  endtask

  task automatic drain();
    int t = 0;
    while (sb.size() > 0 && t < 5000) begin
      @(posedge clk);
      t++;
    end
    chk("drain_empty", sb.size(), 32'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    int t;
    logic [31:0] sv [8];
    i_rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; mode = 1'b0;
    MemInUp = '0; MemInDown = '0;
    s_in_valid = 1'b0; s_out_ready = 1'b1; s_up = '0; s_dn = '0;
    repeat (3) @(posedge clk);
    #1 i_rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_last", {31'd0, out_last}, 32'd0);
    chk("rst_out_index", {27'd0, out_index}, 32'd0);
    chk("rst_small_in_ready", {31'd0, s_in_ready}, 32'd1);
    @(posedge clk);
    #1;

    // single frame, continuous input
    waits = 0;
    send_frame(0, 1'b0, 16);
    chk("frame0_no_stall", waits, 32'd0);
    drain();

    // three frames back to back
    gap_watch = 1; saw_block = 0;
    send_frame(1, 1'b0, 16);
    send_frame(2, 1'b0, 16);
    send_frame(3, 1'b0, 16);
    drain();
    gap_watch = 0;
    chk("b2b_gaps", gaps, 32'd0);
    chk("b2b_in_ready_drop", {31'd0, saw_block}, 32'd1);

    // random backpressure
    rnd_done = 0;
    fork
      begin
        send_frame(4, 1'b0, 16);
        send_frame(5, 1'b0, 16);
        rnd_done = 1;
      end
      begin
        t = 0;
        while (!(rnd_done && sb.size() == 0) && t < 5000) begin
          @(posedge clk);
          #2 out_ready = 1'($urandom_range(0, 1));
          t++;
        end
      end
    join
    out_ready = 1'b1;
    drain();

    // reset mid-frame on both sides
    out_ready = 1'b0;
    send_frame(6, 1'b0, 16);
    out_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1 out_ready = 1'b0;
    send_frame(7, 1'b0, 7);
    in_valid = 1'b1;
    i_rst = 1'b1;
    @(posedge clk);
    #1;
    sb.delete();
    i_rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("mid_rst_out_index", {27'd0, out_index}, 32'd0);
    chk("mid_rst_out_last", {31'd0, out_last}, 32'd0);
    @(posedge clk);
    #1 out_ready = 1'b1;
    send_frame(8, 1'b0, 16);
    drain();

`ifdef PPB_NATURAL_MODE_EN
    send_frame(9, 1'b1, 16);
    drain();
    send_frame(10, 1'b0, 16);
    drain();
`endif

    // 8-point, 16-bit instance with full-scale patterns
    for (int n = 0; n < 8; n++) begin
      sv[n][31:16] = ((n & 1) != 0) ? 16'h8000 : 16'h7FFF;
      sv[n][15:0]  = (((n & 2) != 0) ? 16'h8000 : 16'h7FFF) ^ 16'(n);
    end
    for (int k = 0; k < 4; k++) begin
      s_in_valid = 1'b1;
      s_up = sv[2*k];
      s_dn = sv[2*k+1];
      @(posedge clk);
      #1;
    end
    s_in_valid = 1'b0;
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      chk("small_out_valid", {31'd0, s_out_valid}, 32'd1);
      chk("small_MemOut", s_out, sv[brev(j, 3)]);
      chk("small_out_index", {29'd0, s_out_index}, 32'(j));
      chk("small_out_last", {31'd0, s_out_last}, (j == 7) ? 32'd1 : 32'd0);
    end
    @(negedge clk);
    chk("small_done_out_valid", {31'd0, s_out_valid}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
